gift_round_ctrl: RTL
====================

# gift_round_ctrl

Iterative round controller for the GIFT-128 single-round datapath `layer_Function`. It accepts one plaintext/key pair over a valid/ready handshake and registers the state and round key. It drives `layer_Function` for ROUNDS consecutive cycles, generating the 5-bit round constant and the S-box variant select. It then presents the ciphertext on a valid/ready output with back-pressure. It is the sequencing wrapper around the combinational round and sits between the host interface and the cipher core.

## Interface
Parameters:
- ROUNDS, 40: number of round iterations per block; legal range 1..63.
- CNT_W, 6: round counter width; must satisfy 2^CNT_W > ROUNDS.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  plaintext/key pair offered.
- in_ready  output  1  controller can accept a new block.
- in_plain  input  128  plaintext.
- in_key  input  128  master key.
- in_mode  input  2  S-box variant select, sampled at accept and driven as rcc for every round.
- out_valid  output  1  ciphertext available.
- out_ready  input  1  consumer takes ciphertext.
- out_cipher  output  128  ciphertext, equal to the state register.
- busy  output  1  high in RUN.
- rnd  output  CNT_W  current round index (0..ROUNDS-1), 0 outside RUN.
- core_plain  output  128  to layer_Function `plain`.
- core_key  output  128  to layer_Function `key`.
- core_rcon  output  5  to layer_Function `rcon`.
- core_rcc  output  2  to layer_Function `rcc`.
- core_cipher  input  128  from layer_Function `cipher`.
- core_tkey  input  128  from layer_Function `tkey`.

## Operation
- States: IDLE, RUN, DONE. Registers: st_q[127:0], key_q[127:0], rc_q[4:0], mode_q[1:0], cnt_q[CNT_W-1:0].
- Reset values: state IDLE, all registers 0. Outputs after reset: in_ready=1, out_valid=0, busy=0, rnd=0, out_cipher=0.
- IDLE: in_ready=1. On in_valid && in_ready:
  - st_q←in_plain, key_q←in_key, mode_q←in_mode.
  - rc_q←lfsr(0)=5'h01, cnt_q←0.
  - Transition to RUN.
- RUN: core_plain=st_q, core_key=key_q, core_rcon=rc_q, core_rcc=mode_q. Each edge:
  - st_q←core_cipher, key_q←core_tkey, rc_q←lfsr(rc_q), cnt_q←cnt_q+1.
  - When cnt_q==ROUNDS-1, the same edge moves to DONE and cnt_q clears to 0.
- Round constant LFSR: lfsr(r) = {r[3:0], ~(r[4]^r[2])}. Rounds 0..6 use 01,03,07,0E,1C,19,12 (hex).
- DONE: out_valid=1, out_cipher=st_q held stable. On out_ready, transition to IDLE. st_q is retained, and out_cipher keeps the last result.
- Core outputs in IDLE and DONE still reflect the registers; they are don't-care for downstream.
- in_ready is low in RUN and DONE. in_valid there is ignored, and the offered data must be held by the source.
- rst in any state returns to IDLE with reset values on the next edge. A block in flight is discarded with no out_valid.
- mode_q is fixed for the whole block; in_mode changes during RUN have no effect.

## Timing
- Accept edge = edge 0. The RUN edges are 1..ROUNDS, and out_valid rises after edge ROUNDS.
- Accept-to-out_valid latency is ROUNDS+1 cycles; ROUNDS=40 gives 41.
- With out_ready held high, the DONE→IDLE edge is edge ROUNDS+1, and in_ready is high the following cycle.
- Minimum block period is ROUNDS+2 cycles.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- ROUNDS=1: a single RUN cycle; out_valid after edge 1.

## Structure
- Package gift_ctrl_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - constants RC_INIT=5'h00 and DEF_ROUNDS=40;
  - the lfsr next-state function.
- Sub-module gift_rc_lfsr: 5-bit register with load (to lfsr(0)) and step enables.
- layer_Function is instantiated by the parent, not inside this block.

## Test plan
- Reset, then one block with ROUNDS=40 and out_ready=1, plain=0, key=0, mode=0 -> out_valid high exactly 41 cycles after accept. out_cipher equals 40 iterations of the layer_Function software model.
- Monitor core_rcon during RUN -> 01,03,07,0E,1C,19,12 on rounds 0..6, and rnd steps 0..39. core_rcc equals the in_mode sampled at accept (2'b01), even if in_mode toggles mid-run.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid and out_cipher stable, in_ready=0, and a concurrent in_valid is not accepted. Raising out_ready -> IDLE and in_ready=1 next cycle.
- Assert rst at round 17 -> next cycle IDLE, in_ready=1, rnd=0, out_valid never asserted for that block. A following block completes correctly.
- Back-to-back blocks with in_valid held high -> second accept occurs ROUNDS+2 cycles after the first, and both ciphertexts match the model.
- ROUNDS=1 parameterisation -> out_valid 2 cycles after accept, core_rcon=01 during the single round.

Source files
------------

// File: rtl/gift_ctrl_pkg.sv
// Shared definitions for the GIFT-128 round controller.
//   state_e     : controller state encoding (IDLE, RUN, DONE)
//   RC_INIT     : round-constant register value before the first LFSR step
//   DEF_ROUNDS  : default number of round iterations per block
//   lfsr_next() : 5-bit round-constant LFSR next-state function
package gift_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [4:0] RC_INIT    = 5'h00;
  localparam int         DEF_ROUNDS = 40;

  // Shift left by one and feed back the inverted XOR of bits 4 and 2.
  function automatic logic [4:0] lfsr_next(input logic [4:0] r);
    return {r[3:0], ~(r[4] ^ r[2])};
  endfunction

endpackage

// File: rtl/gift_rc_lfsr.sv
// Round-constant generator for the GIFT-128 round controller.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (register clears to RC_INIT)
//   load : load lfsr(RC_INIT), the constant used by round 0
//   step : advance the LFSR by one round (load has priority)
//   rc_q : current round constant
module gift_rc_lfsr
  import gift_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  output logic [4:0] rc_q
);

  logic [4:0] rc_d;

  // Select load, step or hold for the round-constant register.
  always_comb begin
    rc_d = rc_q;
    if (load) begin
      rc_d = lfsr_next(RC_INIT);
    end else if (step) begin
      rc_d = lfsr_next(rc_q);
    end else begin
      rc_d = rc_q;
    end
  end

  // Round-constant register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rc_q <= RC_INIT;
    end else begin
      rc_q <= rc_d;
    end
  end

endmodule

// File: rtl/gift_round_ctrl.sv
// Iterative round controller wrapped around the combinational GIFT-128
// round (layer_Function, instantiated by the parent).
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   in_valid/in_ready           : plaintext/key/mode input handshake
//   in_plain, in_key, in_mode   : block inputs, sampled at accept
//   out_valid/out_ready         : ciphertext output handshake
//   out_cipher                  : ciphertext (the state register)
//   busy, rnd                   : RUN indicator and current round index
//   core_plain/key/rcon/rcc     : drive the round core
//   core_cipher, core_tkey      : round core results
module gift_round_ctrl
  import gift_ctrl_pkg::*;
#(
  parameter int ROUNDS = DEF_ROUNDS,
  parameter int CNT_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_plain,
  input  logic [127:0]     in_key,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_cipher,
  output logic             busy,
  output logic [CNT_W-1:0] rnd,
  output logic [127:0]     core_plain,
  output logic [127:0]     core_key,
  output logic [4:0]       core_rcon,
  output logic [1:0]       core_rcc,
  input  logic [127:0]     core_cipher,
  input  logic [127:0]     core_tkey
);

  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);

  state_e           state_q, state_d;
  logic [127:0]     st_q, st_d;
  logic [127:0]     key_q, key_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       rc_q;
  logic             rc_load, rc_step;

  gift_rc_lfsr u_rc (
    .clk  (clk),
    .rst  (rst),
    .load (rc_load),
    .step (rc_step),
    .rc_q (rc_q)
  );

  // Next-state and datapath-register update for the controller FSM.
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    key_d   = key_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    rc_load = 1'b0;
    rc_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          st_d    = in_plain;
          key_d   = in_key;
          mode_d  = in_mode;
          cnt_d   = {CNT_W{1'b0}};
          rc_load = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        st_d    = core_cipher;
        key_d   = core_tkey;
        rc_step = 1'b1;
        // The last round's edge also clears the counter so rnd reads 0 in DONE.
        if (cnt_q == LAST_RND) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      st_q    <= 128'h0;
      key_q   <= 128'h0;
      mode_q  <= 2'b00;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      key_q   <= key_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake outputs decode the state register only, so neither ready nor
  // valid has a combinational path from the opposite side of the handshake.
  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q == RUN);
  assign rnd        = busy ? cnt_q : {CNT_W{1'b0}};
  assign out_cipher = st_q;
  assign core_plain = st_q;
  assign core_key   = key_q;
  assign core_rcon  = rc_q;
  assign core_rcc   = mode_q;

endmodule
